// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path definitions: FSM states, line codes, SYNC/stuffing constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        ERROR   = 2'd2
    } state_t;

    // Line states as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Decoded SYNC history, newest bit in the MSB: seven 0s followed by a 1
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    // Consecutive 1s after which the transmitter inserts a 0
    localparam int STUFF_LIMIT = 6;

    // NRZI: no level change means a 1, a level change means a 0
    function automatic logic nrzi_bit(input logic level, input logic prev_level);
        return (level == prev_level);
    endfunction

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Bundle of raw USB line inputs and decoded bit-stream outputs of the receive front end.
// Latency: none (wiring only).
// Backpressure: none; the decoded stream runs at line rate and cannot be stalled.
interface usb_rx_decoder_if;
    logic d_plus;
    logic d_minus;
    logic d_orig;
    logic bit_strobe;
    logic crc_clear;
    logic sync_found;
    logic eop;
    logic rx_active;
    logic rx_error;

    // Decoder side: consumes the line, produces the decoded stream
    modport master (
        input  d_plus, d_minus,
        output d_orig, bit_strobe, crc_clear, sync_found, eop, rx_active, rx_error
    );

    // Line driver / packet controller side
    modport slave (
        output d_plus, d_minus,
        input  d_orig, bit_strobe, crc_clear, sync_found, eop, rx_active, rx_error
    );
endinterface

// File: rtl/usb_bit_timer.sv
// Bit-clock recovery: free-running bit timer, re-zeroed on every dp transition, gives a mid-bit sample strobe.
// Latency: strobe SAMPLE_PHASE+1 clocks after the cycle a dp transition is seen.
// Backpressure: none; strobe is free running.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dp,
    output logic sample
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;
    logic          dp_q;
    logic          edge_det;

    assign edge_det = dp ^ dp_q;

    // Counter wraps once per bit time and is pulled back to zero on each line transition
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt  <= '0;
            dp_q <= 1'b1;
        end else begin
            dp_q <= dp;
            if (edge_det || (cnt == CW'(CLKS_PER_BIT - 1)))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // A transition landing on the sample count restarts the bit, so it must not also be sampled
    assign sample = (cnt == CW'(SAMPLE_PHASE)) && !edge_det;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB RX front end: line sync, NRZI decode, bit unstuffing, SYNC/EOP detection, decoded bit stream out.
// Latency: 2 clk synchroniser, then every decision registered 1 clk after its sample strobe.
// Backpressure: none; one bit per strobe at line rate, consumer must keep up.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_rx_decoder_if.master bus
);
    // [0] is the metastability stage, [1] the stable copy
    logic [1:0] dp_sync;
    logic [1:0] dm_sync;
    logic       dp;
    logic       dm;
    logic [1:0] line;
    logic       sample;

    state_t     state;
    logic       prev_level;
    logic [1:0] se0_cnt;
    logic [2:0] ones_cnt;
    logic [7:0] shift;
    logic       bit_val;
    logic [7:0] shift_next;

    logic       d_orig_q;
    logic       bit_strobe_q;
    logic       sync_q;
    logic       eop_q;
    logic       rx_active_q;
    logic       rx_error_q;

    // Two-flop synchronisers, resetting to the J idle state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
        end else begin
            dp_sync <= {dp_sync[0], bus.d_plus};
            dm_sync <= {dm_sync[0], bus.d_minus};
        end
    end

    assign dp   = dp_sync[1];
    assign dm   = dm_sync[1];
    assign line = {dp, dm};

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .dp     (dp),
        .sample (sample)
    );

    assign bit_val    = nrzi_bit(dp, prev_level);
    assign shift_next = {bit_val, shift[7:1]};

    // Receive FSM; all outputs registered, pulses last one clock.
    // The SYNC history idles at all-ones so a plain J after reset or SE0 can never complete a SYNC.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            prev_level   <= 1'b1;
            se0_cnt      <= 2'd0;
            ones_cnt     <= 3'd0;
            shift        <= 8'hFF;
            d_orig_q     <= 1'b1;
            bit_strobe_q <= 1'b0;
            sync_q       <= 1'b0;
            eop_q        <= 1'b0;
            rx_active_q  <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            bit_strobe_q <= 1'b0;
            sync_q       <= 1'b0;
            eop_q        <= 1'b0;
            if (sample) begin
                if (line == LINE_SE0) begin
                    if (se0_cnt != 2'd2)
                        se0_cnt <= se0_cnt + 2'd1;
                    // EOP is the second consecutive SE0 bit; a lone SE0 delivers nothing
                    case (state)
                        IDLE: shift <= 8'hFF;
                        RECEIVE: begin
                            if (se0_cnt != 2'd0) begin
                                eop_q       <= 1'b1;
                                rx_active_q <= 1'b0;
                                prev_level  <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                        ERROR: begin
                            if (se0_cnt != 2'd0) begin
                                eop_q       <= 1'b1;
                                rx_active_q <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end else begin
                    se0_cnt    <= 2'd0;
                    prev_level <= dp;
                    case (state)
                        IDLE: begin
                            if (shift_next == SYNC_PATTERN) begin
                                sync_q      <= 1'b1;
                                rx_error_q  <= 1'b0;
                                rx_active_q <= 1'b1;
                                ones_cnt    <= 3'd0;
                                shift       <= 8'hFF;
                                state       <= RECEIVE;
                            end else begin
                                shift <= shift_next;
                            end
                        end
                        RECEIVE: begin
                            if (ones_cnt == 3'(STUFF_LIMIT)) begin
                                // Bit after six 1s must be a stuffed 0; it is never delivered
                                if (bit_val) begin
                                    rx_error_q <= 1'b1;
                                    state      <= ERROR;
                                end
                                ones_cnt <= 3'd0;
                            end else begin
                                d_orig_q     <= bit_val;
                                bit_strobe_q <= 1'b1;
                                ones_cnt     <= bit_val ? (ones_cnt + 3'd1) : 3'd0;
                            end
                        end
                        ERROR: begin
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.d_orig     = d_orig_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.crc_clear  = sync_q;
    assign bus.sync_found = sync_q;
    assign bus.eop        = eop_q;
    assign bus.rx_active  = rx_active_q;
    assign bus.rx_error   = rx_error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: table of packets plus hand sequences for SE0, jitter, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_usb_rx_decoder;
    import usb_rx_pkg::*;

    logic clk;
    logic n_rst;

    usb_rx_decoder_if bus();

    usb_rx_decoder #(
        .CLKS_PER_BIT (8),
        .SAMPLE_PHASE (3)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse / strobe monitor; the main sequence only reads these
    int   n_strobe = 0;
    int   n_sync   = 0;
    int   n_clr    = 0;
    int   n_eop    = 0;
    int   n_pair   = 0;
    logic cap [0:4095];

    always @(negedge clk) begin
        if (bus.bit_strobe) begin
            cap[n_strobe % 4096] = bus.d_orig;
            n_strobe = n_strobe + 1;
        end
        if (bus.sync_found) n_sync = n_sync + 1;
        if (bus.crc_clear)  n_clr  = n_clr + 1;
        if (bus.eop)        n_eop  = n_eop + 1;
        if (bus.sync_found != bus.crc_clear) n_pair = n_pair + 1;
    end

    typedef struct {
        logic [15:0] raw;       // line-level decoded bits, bit i sent i-th
        int          n_raw;
        int          exp_n;     // expected delivered strobes
        logic [15:0] exp_bits;  // bit i = i-th delivered d_orig
        logic        exp_err;
    } vec_t;

    vec_t vt [7];

    logic lvl = 1'b1;
    logic jit = 1'b0;
    logic tog = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic line_sym(input logic [1:0] sym);
        int per;
        bus.d_plus  = sym[1];
        bus.d_minus = sym[0];
        if (jit) begin
            per = tog ? 7 : 9;
            tog = ~tog;
        end else begin
            per = 8;
        end
        repeat (per) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (!b) lvl = ~lvl;
        line_sym(lvl ? LINE_J : LINE_K);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_eop();
        line_sym(LINE_SE0);
        line_sym(LINE_SE0);
        lvl = 1'b1;
        line_sym(LINE_J);
    endtask

    task automatic idle_j(input int n);
        lvl = 1'b1;
        repeat (n) line_sym(LINE_J);
    endtask

    function automatic int get_bits(input int base, input int n);
        int r;
        r = 0;
        for (int i = 0; i < n; i++)
            if (cap[(base + i) % 4096]) r = r | (1 << i);
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int s0, y0, c0, e0, p0;
        s0 = n_strobe; y0 = n_sync; c0 = n_clr; e0 = n_eop; p0 = n_pair;
        send_sync();
        #1;
        chk({tag, "_sync_pulse"},  n_sync - y0, 1);
        chk({tag, "_crc_clear"},   n_clr - c0, 1);
        chk({tag, "_active"},      int'(bus.rx_active), 1);
        chk({tag, "_err_cleared"}, int'(bus.rx_error), 0);
        for (int i = 0; i < v.n_raw; i++) send_bit(v.raw[i]);
        chk({tag, "_active_pkt"},  int'(bus.rx_active), 1);
        chk({tag, "_no_early_eop"}, n_eop - e0, 0);
        send_eop();
        idle_j(2);
        #1;
        chk({tag, "_strobes"}, n_strobe - s0, v.exp_n);
        chk({tag, "_bits"},    get_bits(s0, v.exp_n), int'(v.exp_bits));
        chk({tag, "_err"},     int'(bus.rx_error), int'(v.exp_err));
        chk({tag, "_eop"},     n_eop - e0, 1);
        chk({tag, "_inactive"}, int'(bus.rx_active), 0);
        chk({tag, "_pair"},    n_pair - p0, 0);
    endtask

    initial begin
        int s0, y0, e0;
        vec_t va5;

        vt[0] = '{16'h00A5,  8, 8, 16'h00A5, 1'b0};  // byte 0xA5
        vt[1] = '{16'h00BF,  8, 7, 16'h007F, 1'b0};  // seven 1s with stuffed 0
        vt[2] = '{16'h007F,  7, 6, 16'h003F, 1'b1};  // stuff error
        vt[3] = '{16'h0000,  8, 8, 16'h0000, 1'b0};  // all zeros, rx_error cleared by sync
        vt[4] = '{16'h01BF,  9, 8, 16'h00FF, 1'b0};  // 0xFF with stuffed 0
        vt[5] = '{16'h00FE, 10, 7, 16'h007E, 1'b1};  // stuff error after a 0
        vt[6] = '{16'h003C,  8, 8, 16'h003C, 1'b0};  // 0x3C after an error packet
        va5   = vt[0];

        // Reset held with J idle
        n_rst = 1'b0;
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("rst_d_orig",     int'(bus.d_orig), 1);
        chk("rst_rx_active",  int'(bus.rx_active), 0);
        chk("rst_rx_error",   int'(bus.rx_error), 0);
        chk("rst_eop",        int'(bus.eop), 0);
        chk("rst_sync_found", int'(bus.sync_found), 0);
        chk("rst_crc_clear",  int'(bus.crc_clear), 0);
        chk("rst_no_strobes", n_strobe, 0);
        n_rst = 1'b1;
        idle_j(20);
        #1;
        chk("idle_no_sync",    n_sync, 0);
        chk("idle_no_strobes", n_strobe, 0);

        // Table-driven packets
        for (int k = 0; k < 7; k++) run_vec(vt[k], $sformatf("vec%0d", k));

        // Single SE0 mid-packet is not an EOP
        s0 = n_strobe; e0 = n_eop;
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        line_sym(LINE_SE0);
        send_bit(1'b0); send_bit(1'b1);
        #1;
        chk("se0_single_no_eop", n_eop - e0, 0);
        chk("se0_single_active", int'(bus.rx_active), 1);
        send_eop();
        idle_j(2);
        #1;
        chk("se0_strobes", n_strobe - s0, 6);
        chk("se0_bits",    get_bits(s0, 6), 'h2D);
        chk("se0_eop",     n_eop - e0, 1);

        // Bit periods alternating 7 and 9 clocks
        s0 = n_strobe; e0 = n_eop;
        jit = 1'b1;
        tog = 1'b0;
        send_sync();
        for (int i = 0; i < 16; i++) send_bit(((16'h3CA5 >> i) & 1) != 0);
        send_eop();
        jit = 1'b0;
        idle_j(2);
        #1;
        chk("jit_strobes", n_strobe - s0, 16);
        chk("jit_bits",    get_bits(s0, 16), 'h3CA5);
        chk("jit_eop",     n_eop - e0, 1);

        // Reset mid-byte, then a clean packet
        y0 = n_sync; e0 = n_eop;
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #1;
        chk("mid_pre_active", int'(bus.rx_active), 1);
        chk("mid_pre_d_orig", int'(bus.d_orig), 0);
        @(negedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_active", int'(bus.rx_active), 0);
        chk("mid_rst_d_orig", int'(bus.d_orig), 1);
        chk("mid_rst_error",  int'(bus.rx_error), 0);
        chk("mid_rst_strobe", int'(bus.bit_strobe), 0);
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        idle_j(4);
        #1;
        chk("mid_no_eop",  n_eop - e0, 0);
        chk("mid_one_sync", n_sync - y0, 1);
        run_vec(va5, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
